control_sequencer: RTL and testbench

- Multi-cycle hardwired control unit that sits directly upstream of the phase-1 datapath.
- Watches IR_data_out and a memory-ready handshake.
- Each cycle, generates every enable and select strobe the datapath consumes: register in/out, PC, IR, Y, Z, HI/LO, MAR/MDR, Read, ALUControl.
- Sequences fetch, decode and execute for register-format ALU, multiply/divide, unary, nop and halt instructions.

---
 rtl/control_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch / decode / execute sequencing
// and per-cycle datapath strobe generation for the phase-1 datapath.
module control_sequencer #(
  parameter int unsigned REG_COUNT  = 16,
  parameter int unsigned ALU_CTRL_W = 5
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic [31:0]           IR,
  input  logic                  MemReady,
  output logic                  PCout,
  output logic                  IncrementPC,
  output logic                  IRin,
  output logic                  MARin,
  output logic                  MDRin,
  output logic                  MDRout,
  output logic                  Read,
  output logic                  Yin,
  output logic                  Zin,
  output logic                  ZHIout,
  output logic                  ZLOout,
  output logic                  HIin,
  output logic                  LOin,
  output logic [REG_COUNT-1:0]  Rin,
  output logic [REG_COUNT-1:0]  Rout,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  Halted,
  output logic                  Illegal,
  output logic [31:0]           InstrCount
);

  typedef enum logic [3:0] {
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StHalt
  } state_e;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpRol  = 5'b01011;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  state_e      state_q, state_d;
  logic [31:0] instr_count_q;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_muldiv, is_unary, is_nop, is_halt;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  // Register-format ALU ops occupy the contiguous range add..rol.
  assign is_alu    = (opcode >= OpAdd) && (opcode <= OpRol);
  assign is_muldiv = (opcode == OpMul) || (opcode == OpDiv);
  assign is_unary  = (opcode == OpNeg) || (opcode == OpNot);
  assign is_nop    = (opcode == OpNop);
  assign is_halt   = (opcode == OpHalt);

  function automatic logic [REG_COUNT-1:0] onehot(input logic [3:0] idx);
    onehot = REG_COUNT'(1) << idx;
  endfunction

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q       <= StT0;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StT2) begin
        instr_count_q <= instr_count_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StT0: state_d = StT1;
      StT1: state_d = MemReady ? StT2 : StT1;
      StT2: state_d = StT3;
      StT3: begin
        if (is_alu || is_muldiv || is_unary) begin
          state_d = StT4;
        end else if (is_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StT0;
        end
      end
      StT4:    state_d = (is_alu || is_muldiv) ? StT5 : StT0;
      StT5:    state_d = is_muldiv ? StT6 : StT0;
      StT6:    state_d = StT0;
      StHalt:  state_d = StHalt;
      default: state_d = StT0;
    endcase
  end

  always_comb begin
    PCout       = 1'b0;
    IncrementPC = 1'b0;
    IRin        = 1'b0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    Read        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    ZHIout      = 1'b0;
    ZLOout      = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    Rin         = '0;
    Rout        = '0;
    ALUControl  = '0;
    Halted      = 1'b0;
    Illegal     = 1'b0;

    unique case (state_q)
      StT0: begin
        PCout       = 1'b1;
        MARin       = 1'b1;
        IncrementPC = 1'b1;
      end
      StT1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        if (is_alu) begin
          Rout = onehot(rb);
          Yin  = 1'b1;
        end else if (is_muldiv) begin
          Rout = onehot(ra);
          Yin  = 1'b1;
        end else if (is_unary) begin
          Rout       = onehot(rb);
          ALUControl = ALU_CTRL_W'(opcode);
          Zin        = 1'b1;
        end else if (!is_nop && !is_halt) begin
          Illegal = 1'b1;
        end
      end
      StT4: begin
        if (is_alu) begin
          Rout       = onehot(rc);
          ALUControl = ALU_CTRL_W'(opcode);
          Zin        = 1'b1;
        end else if (is_muldiv) begin
          Rout       = onehot(rb);
          ALUControl = ALU_CTRL_W'(opcode);
          Zin        = 1'b1;
        end else if (is_unary) begin
          ZLOout = 1'b1;
          Rin    = onehot(ra);
        end
      end
      StT5: begin
        ZLOout = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else if (is_alu) begin
          Rin = onehot(ra);
        end
      end
      StT6: begin
        ZHIout = 1'b1;
        HIin   = 1'b1;
      end
      StHalt: Halted = 1'b1;
      default: ;
    endcase

    // Clear dominates so nothing reaches the datapath from an abandoned instruction.
    if (Clear) begin
      PCout       = 1'b0;
      IncrementPC = 1'b0;
      IRin        = 1'b0;
      MARin       = 1'b0;
      MDRin       = 1'b0;
      MDRout      = 1'b0;
      Read        = 1'b0;
      Yin         = 1'b0;
      Zin         = 1'b0;
      ZHIout      = 1'b0;
      ZLOout      = 1'b0;
      HIin        = 1'b0;
      LOin        = 1'b0;
      Rin         = '0;
      Rout        = '0;
      ALUControl  = '0;
      Halted      = 1'b0;
      Illegal     = 1'b0;
    end
  end

  assign InstrCount = Clear ? 32'd0 : instr_count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes per-cycle expected
// strobe vectors, a negedge monitor pops and compares them.
module tb_control_sequencer;

  typedef struct packed {
    logic        pc_out;
    logic        inc_pc;
    logic        ir_in;
    logic        mar_in;
    logic        mdr_in;
    logic        mdr_out;
    logic        rd;
    logic        y_in;
    logic        z_in;
    logic        zhi_out;
    logic        zlo_out;
    logic        hi_in;
    logic        lo_in;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        halted;
    logic        illegal;
  } strobe_t;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic [31:0] mdatain;

  logic        pc_out, inc_pc, ir_in, mar_in, mdr_in, mdr_out, rd;
  logic        y_in, z_in, zhi_out, zlo_out, hi_in, lo_in;
  logic [15:0] rin, rout;
  logic [4:0]  alu;
  logic        halted, illegal;
  logic [31:0] instr_count;

  strobe_t     act;
  strobe_t     exp_q[$];
  logic [31:0] cnt_q[$];
  string       name_q[$];
  logic [31:0] exp_cnt;
  int          applied = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  control_sequencer #(
    .REG_COUNT (16),
    .ALU_CTRL_W(5)
  ) dut (
    .Clock      (clk),
    .Clear      (clear),
    .IR         (ir),
    .MemReady   (mem_ready),
    .PCout      (pc_out),
    .IncrementPC(inc_pc),
    .IRin       (ir_in),
    .MARin      (mar_in),
    .MDRin      (mdr_in),
    .MDRout     (mdr_out),
    .Read       (rd),
    .Yin        (y_in),
    .Zin        (z_in),
    .ZHIout     (zhi_out),
    .ZLOout     (zlo_out),
    .HIin       (hi_in),
    .LOin       (lo_in),
    .Rin        (rin),
    .Rout       (rout),
    .ALUControl (alu),
    .Halted     (halted),
    .Illegal    (illegal),
    .InstrCount (instr_count)
  );

  // Datapath IR register: captures the memory word when IRin is strobed.
  always @(posedge clk) begin
    if (ir_in) ir <= mdatain;
  end

  assign act = {pc_out, inc_pc, ir_in, mar_in, mdr_in, mdr_out, rd, y_in, z_in, zhi_out,
                zlo_out, hi_in, lo_in, rin, rout, alu, halted, illegal};

  always @(negedge clk) begin
    strobe_t     e;
    logic [31:0] c;
    string       n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      c = cnt_q.pop_front();
      n = name_q.pop_front();
      applied++;
      if (act !== e || instr_count !== c) begin
        errors++;
        $display("FAIL %s: got strobes=%h count=%0d, expected strobes=%h count=%0d",
                 n, act, instr_count, e, c);
      end
    end
  end

  task automatic cyc(input strobe_t e, input string nm);
    exp_q.push_back(e);
    cnt_q.push_back(exp_cnt);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] word, input int stall);
    strobe_t e;
    e = '0; e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1;
    mem_ready = 1'b0;
    cyc(e, "t0");
    mdatain = word;
    e = '0; e.rd = 1'b1; e.mdr_in = 1'b1;
    for (int i = 0; i < stall; i++) cyc(e, "t1_stall");
    mem_ready = 1'b1;
    cyc(e, "t1_ready");
    mem_ready = 1'b0;
    e = '0; e.mdr_out = 1'b1; e.ir_in = 1'b1;
    cyc(e, "t2");
    exp_cnt = exp_cnt + 32'd1;
  endtask

  // Three-cycle execute of a register-format ALU op.
  task automatic exec_alu(input logic [15:0] rb_oh, input logic [15:0] rc_oh,
                          input logic [15:0] ra_oh, input logic [4:0] op);
    strobe_t e;
    e = '0; e.rout = rb_oh; e.y_in = 1'b1;                 cyc(e, "alu_t3");
    e = '0; e.rout = rc_oh; e.alu = op; e.z_in = 1'b1;     cyc(e, "alu_t4");
    e = '0; e.zlo_out = 1'b1; e.rin = ra_oh;               cyc(e, "alu_t5");
  endtask

  task automatic exec_muldiv(input logic [15:0] ra_oh, input logic [15:0] rb_oh,
                             input logic [4:0] op);
    strobe_t e;
    e = '0; e.rout = ra_oh; e.y_in = 1'b1;                 cyc(e, "md_t3");
    e = '0; e.rout = rb_oh; e.alu = op; e.z_in = 1'b1;     cyc(e, "md_t4");
    e = '0; e.zlo_out = 1'b1; e.lo_in = 1'b1;              cyc(e, "md_t5");
    e = '0; e.zhi_out = 1'b1; e.hi_in = 1'b1;              cyc(e, "md_t6");
  endtask

  initial begin
    strobe_t e;
    clear     = 1'b1;
    mem_ready = 1'b0;
    mdatain   = '0;
    ir        = '0;
    exp_cnt   = '0;
    @(posedge clk);
    #1;
    e = '0;
    cyc(e, "reset");
    clear = 1'b0;

    // nop with a 3-cycle memory stall
    fetch(32'hD000_0000, 3);
    e = '0; cyc(e, "nop_t3");

    // add R3,R1,R2
    fetch(32'h1989_0000, 0);
    exec_alu(16'h0002, 16'h0004, 16'h0008, 5'b00011);

    // sub R5,R5,R5 (full aliasing)
    fetch(32'h22AA_8000, 1);
    exec_alu(16'h0020, 16'h0020, 16'h0020, 5'b00100);

    // mul R4,R5
    fetch(32'h7A28_0000, 0);
    exec_muldiv(16'h0010, 16'h0020, 5'b01111);

    // div R9,R10
    fetch(32'h84D0_0000, 2);
    exec_muldiv(16'h0200, 16'h0400, 5'b10000);

    // neg R6,R7
    fetch(32'h8B38_0000, 0);
    e = '0; e.rout = 16'h0080; e.alu = 5'b10001; e.z_in = 1'b1; cyc(e, "neg_t3");
    e = '0; e.zlo_out = 1'b1; e.rin = 16'h0040;                  cyc(e, "neg_t4");

    // undefined opcode 11111
    fetch(32'hF800_0000, 0);
    e = '0; e.illegal = 1'b1; cyc(e, "illegal_t3");

    // add, then Clear during T4
    fetch(32'h1989_0000, 0);
    e = '0; e.rout = 16'h0002; e.y_in = 1'b1; cyc(e, "add_t3_pre_clear");
    clear   = 1'b1;
    exp_cnt = '0;
    e = '0; cyc(e, "clear_in_t4");
    clear = 1'b0;

    // halt, hold, then Clear
    fetch(32'hD800_0000, 0);
    e = '0; cyc(e, "halt_t3");
    e = '0; e.halted = 1'b1;
    for (int i = 0; i < 22; i++) cyc(e, "halted");
    clear   = 1'b1;
    exp_cnt = '0;
    e = '0; cyc(e, "clear_from_halt");
    clear = 1'b0;
    fetch(32'hD000_0000, 0);
    e = '0; cyc(e, "nop_after_halt");

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
